// File: rtl/johnson_sequence_monitor.sv
// rtl/johnson_sequence_monitor.sv - Johnson counter sequence monitor (optional JSM_STICKY_ERR_EN sticky error flag)
// Checks the upstream Johnson pattern/state stream and tracks lock, errors, polarity and wraps.

module johnson_sequence_monitor (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Sample,
   input  logic [3:0] Q_in,
   input  logic [2:0] State_in,
   input  logic       ClearErr,
   output logic       Locked,
   output logic       ErrorFlag,
   output logic [7:0] ErrorCount,
   output logic       Inverted,
   output logic       PolarityToggle,
   output logic [7:0] WrapCount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      FAULT   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] prev_q, prev_d;
   logic       locked_q;
   logic       err_flag_q, err_flag_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       inverted_q, inverted_d;
   logic       toggle_q, toggle_d;
   logic [7:0] wrap_q, wrap_d;

   logic [3:0] expected;
   logic       valid_true;
   logic       valid_inv;
   logic       valid;
   logic       in_seq;
   logic       reject;
   logic       wrap_hit;

   function automatic logic [3:0] johnson_pattern(input logic [2:0] s);
      logic [3:0] p;
      case (s)
         3'd0:    p = 4'b0000;
         3'd1:    p = 4'b1000;
         3'd2:    p = 4'b1100;
         3'd3:    p = 4'b1110;
         3'd4:    p = 4'b1111;
         3'd5:    p = 4'b0111;
         3'd6:    p = 4'b0011;
         default: p = 4'b0001;
      endcase
      return p;
   endfunction

   assign expected   = johnson_pattern(State_in);
   assign valid_true = (Q_in == expected);
   assign valid_inv  = (Q_in == ~expected);
   assign valid      = valid_true | valid_inv;
   assign in_seq     = (State_in == prev_q + 3'd1);

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      reject   = 1'b0;
      wrap_hit = 1'b0;
      if (Sample) begin
         unique case (state_q)
            IDLE: begin
               // Invalid samples before the first valid one are ignored, not counted.
               if (valid) begin
                  state_d = ACQUIRE;
                  prev_d  = State_in;
               end
            end
            ACQUIRE: begin
               if (valid && in_seq) begin
                  state_d = LOCKED;
                  prev_d  = State_in;
               end else begin
                  state_d = FAULT;
                  reject  = 1'b1;
               end
            end
            LOCKED: begin
               if (valid && in_seq) begin
                  prev_d   = State_in;
                  wrap_hit = (prev_q == 3'd7);
               end else begin
                  state_d = FAULT;
                  reject  = 1'b1;
               end
            end
            FAULT: begin
               if (valid) begin
                  state_d = ACQUIRE;
                  prev_d  = State_in;
               end else begin
                  reject = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      inverted_d = inverted_q;
      toggle_d   = 1'b0;
      if (Sample && valid) begin
         inverted_d = valid_inv;
         toggle_d   = (valid_inv != inverted_q);
      end
   end

   assign err_cnt_d = (reject && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   assign wrap_d    = wrap_hit ? wrap_q + 8'd1 : wrap_q;

`ifdef JSM_STICKY_ERR_EN
   // A reject in the same cycle as ClearErr wins so no error is lost.
   assign err_flag_d = reject | (err_flag_q & ~ClearErr);
`else
   logic unused_clear_err;
   assign unused_clear_err = ClearErr;
   assign err_flag_d       = reject;
`endif

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q    <= IDLE;
         prev_q     <= 3'd0;
         locked_q   <= 1'b0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= 8'd0;
         inverted_q <= 1'b0;
         toggle_q   <= 1'b0;
         wrap_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         locked_q   <= (state_d == LOCKED);
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
         inverted_q <= inverted_d;
         toggle_q   <= toggle_d;
         wrap_q     <= wrap_d;
      end
   end

   assign Locked         = locked_q;
   assign ErrorFlag      = err_flag_q;
   assign ErrorCount     = err_cnt_q;
   assign Inverted       = inverted_q;
   assign PolarityToggle = toggle_q;
   assign WrapCount      = wrap_q;

endmodule

// File: doc/johnson_sequence_monitor.md
JOHNSON_SEQUENCE_MONITOR -- requirements
Module: johnson_sequence_monitor

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge, half a period after the upstream counter's falling-edge update.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-003 SHALL have port Sample, input, 1 bit: high for one CLK cycle per upstream counter step; qualifies Q_in and State_in.
REQ-004 SHALL have port Q_in, input, 4 bits: Johnson pattern from the upstream counter.
REQ-005 SHALL have port State_in, input, 3 bits: upstream state number, 0..7.
REQ-006 SHALL have port ClearErr, input, 1 bit: clears the sticky error flag (used only with JSM_STICKY_ERR_EN).
REQ-007 SHALL have port Locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-008 SHALL have port ErrorFlag, output, 1 bit: error indication, as set by REQ-023.
REQ-009 SHALL have port ErrorCount, output, 8 bits: saturating count of rejected samples.
REQ-010 SHALL have port Inverted, output, 1 bit: polarity of the last valid sample (1 = complemented).
REQ-011 SHALL have port PolarityToggle, output, 1 bit: one-cycle pulse when Inverted changes.
REQ-012 SHALL have port WrapCount, output, 8 bits: count of 7->0 transitions seen while LOCKED, modulo 256.

Function
REQ-013 SHALL use this reference table, state:pattern: 0:0000, 1:1000, 2:1100, 3:1110, 4:1111, 5:0111, 6:0011, 7:0001.
REQ-014 SHALL classify a sample as follows: valid-true if Q_in equals table[State_in]; valid-inverted if Q_in equals ~table[State_in]; otherwise pattern error.
REQ-015 SHALL treat a sample as in-sequence when State_in equals (previous accepted State_in + 1) mod 8, with 7->0 wrap.
REQ-016 SHALL implement FSM states IDLE, ACQUIRE, LOCKED and FAULT; IDLE is the reset state.
REQ-017 IDLE SHALL move to ACQUIRE on the first valid sample (either polarity), storing its State_in; an invalid sample SHALL leave it in IDLE and SHALL NOT be counted.
REQ-018 ACQUIRE SHALL move to LOCKED on a valid, in-sequence sample; on any other sample it SHALL move to FAULT.
REQ-019 LOCKED SHALL stay on a valid, in-sequence sample and SHALL move to FAULT otherwise (pattern error or sequence skip, repeat, or reversal).
REQ-020 FAULT SHALL move to ACQUIRE on the next valid sample, re-seeding the stored State_in from it, and SHALL stay in FAULT on an invalid sample.
REQ-021 Cycles with Sample=0 SHALL change no state, counter or flag, except that the PolarityToggle pulse returns low.
REQ-022 Every sample rejected in ACQUIRE, LOCKED or FAULT SHALL increment ErrorCount, saturating at 255 with no wrap.
REQ-023 ErrorFlag without the macro SHALL be a one-cycle pulse in the cycle after a rejected sample.
REQ-024 Inverted SHALL update on every valid sample in any state; PolarityToggle SHALL pulse for one cycle when the new value differs from the old, and a polarity change alone SHALL NOT be an error.
REQ-025 WrapCount SHALL increment only on an accepted 7->0 sample while in LOCKED.
REQ-026 All outputs SHALL be registered, with results visible one CLK cycle after the sampling edge.

Reset
REQ-027 When Reset=0 at a rising edge, it SHALL override Sample and ClearErr.
REQ-028 Reset SHALL force: FSM to IDLE; Locked, ErrorFlag, Inverted and PolarityToggle to 0; ErrorCount and WrapCount to 0; stored state to 0.
REQ-029 A reset asserted mid-LOCKED SHALL discard the history, so the first sample after reset follows the IDLE rules.

Configuration
REQ-030 With JSM_STICKY_ERR_EN defined, ErrorFlag SHALL be set on a rejected sample and hold until ClearErr=1 or reset.
REQ-031 Under JSM_STICKY_ERR_EN, a rejected sample coinciding with ClearErr SHALL leave ErrorFlag set.
REQ-032 Under JSM_STICKY_ERR_EN, ClearErr SHALL NOT affect ErrorCount.
REQ-033 Without JSM_STICKY_ERR_EN, ErrorFlag SHALL behave as in REQ-023 and ClearErr SHALL be ignored.

Verification
REQ-034 SHALL check: reset, then samples of states 0..7,0 with true patterns -> Locked=1 after the 2nd sample, WrapCount=1, ErrorCount=0.
REQ-035 SHALL check: while LOCKED at state 3, feed state 5 with pattern 0111 -> FSM enters FAULT, Locked=0, ErrorCount=1, ErrorFlag pulses.
REQ-036 SHALL check: while LOCKED at state 2, feed state 3 with 0001 (~1110) -> stays LOCKED, Inverted=1, one PolarityToggle pulse, no error.
REQ-037 SHALL check: 300 consecutive pattern errors after lock -> ErrorCount holds 255.
REQ-038 SHALL check: Reset=0 together with Sample=1 while LOCKED -> next cycle shows IDLE and all outputs 0.
REQ-039 SHALL check, with JSM_STICKY_ERR_EN: error, then 5 clean samples -> ErrorFlag still 1; ClearErr pulse -> ErrorFlag 0 and ErrorCount unchanged.
